// File: rtl/attack_uart_tx.sv
// attack_uart_tx: sends the 16-bit attack vector as two 8N1 bytes, low byte first; define ATTACK_TX_PARITY_EN for an even-parity bit per byte.
module attack_uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        activate,
  input  logic [15:0] attack,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef ATTACK_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          byte_idx, byte_n;
  logic [15:0]   data, data_n;
  logic          tx_n, busy_n, done_n, act_q, last;
  logic [7:0]    cur;
  assign last = cnt == CW'(CPB - 1);
  assign cur  = byte_idx ? data[15:8] : data[7:0];
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    data_n  = data;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (activate && !act_q) begin
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          data_n  = attack;
          bit_n   = '0;
          byte_n  = 1'b0;
        end
      end
      START: if (last) begin
        state_n = DATA;
        cnt_n   = '0;
        bit_n   = '0;
        tx_n    = cur[0];
      end
      DATA: if (last) begin
        cnt_n = '0;
        bit_n = bit_cnt + 3'd1;
        tx_n  = cur[bit_cnt + 3'd1];
        if (bit_cnt == 3'd7) begin
`ifdef ATTACK_TX_PARITY_EN
          state_n = PARITY;
          tx_n    = ^cur;
`else
          state_n = STOP;
          tx_n    = 1'b1;
`endif
        end
      end
`ifdef ATTACK_TX_PARITY_EN
      PARITY: if (last) begin
        state_n = STOP;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
`endif
      STOP: if (last) begin
        cnt_n = '0;
        // second byte's start bit follows the first stop bit with no gap
        if (!byte_idx) begin
          state_n = START;
          byte_n  = 1'b1;
          tx_n    = 1'b0;
        end else begin
          state_n = IDLE;
          byte_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      data     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      act_q    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      byte_idx <= byte_n;
      data     <= data_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      act_q    <= activate;
    end
endmodule

// File: tb/tb_attack_uart_tx.sv
// tb_attack_uart_tx: self-checking bench for attack_uart_tx at 16 clocks per bit (honours ATTACK_TX_PARITY_EN).
module tb_attack_uart_tx;
  localparam int C = 16;
`ifdef ATTACK_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = 2 * NB * C;
  typedef struct {
    logic [15:0] a;
    logic [0:19] seq;
    logic        p0;
    logic        p1;
  } vec_t;
  logic clk, clr, activate, tx, busy, done;
  logic [15:0] attack;
  logic exp_q[$];
  vec_t tab[6];
  int checks = 0, failures = 0;
  attack_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .clr(clr), .activate(activate), .attack(attack),
    .tx(tx), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_tx"}, tx, 1'b1);
    chk({n, "_busy"}, busy, 1'b0);
    chk({n, "_done"}, done, 1'b0);
  endtask
  // reference: start, 8 data bits LSB first, optional even parity, stop, per byte
  task automatic build_exp(input logic [15:0] a);
    exp_q = {};
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(a[8*b+i]);
`ifdef ATTACK_TX_PARITY_EN
      exp_q.push_back(^a[8*b +: 8]);
`endif
      exp_q.push_back(1'b1);
    end
  endtask
  task automatic build_tab(input vec_t v);
    exp_q = {};
    for (int i = 0; i < 20; i++) begin
`ifdef ATTACK_TX_PARITY_EN
      if (i == 9) exp_q.push_back(v.p0);
      if (i == 19) exp_q.push_back(v.p1);
`endif
      exp_q.push_back(v.seq[i]);
    end
  endtask
  task automatic start_req(input logic [15:0] a);
    activate = 1'b0;
    @(negedge clk);
    attack = a;
    activate = 1'b1;
    @(negedge clk);
  endtask
  // t=0 is the sample right after the accepting edge; mode 0 plain, 1 noisy inputs, 2 held level, 3 back-to-back
  task automatic observe(input int len, input int mode, input logic [15:0] nxt);
    for (int t = 0; t < len; t++) begin
      chk("tx", tx, t < F ? exp_q[t / C] : 1'b1);
      chk("busy", busy, 1'(t < F));
      chk("done", done, 1'(t == F));
      case (mode)
        1: begin
          activate = (t < F - 1) ? 1'($urandom) : 1'b0;
          attack = 16'($urandom);
        end
        2: begin
          activate = (t != 98);
          if (t >= 49) attack = 16'hFFFF;
        end
        3: begin
          activate = (t == F);
          if (t == F) attack = nxt;
        end
        default: activate = 1'b0;
      endcase
      if (t < len - 1) @(negedge clk);
    end
  endtask
  initial begin
    tab[0] = '{16'hA55A, 20'b0_01011010_1_0_10100101_1, 1'b0, 1'b0};
    tab[1] = '{16'h0001, 20'b0_10000000_1_0_00000000_1, 1'b1, 1'b0};
    tab[2] = '{16'h8000, 20'b0_00000000_1_0_00000001_1, 1'b0, 1'b1};
    tab[3] = '{16'h0703, 20'b0_11000000_1_0_11100000_1, 1'b0, 1'b1};
    tab[4] = '{16'hFFFF, 20'b0_11111111_1_0_11111111_1, 1'b0, 1'b0};
    tab[5] = '{16'h1234, 20'b0_00101100_1_0_01001000_1, 1'b1, 1'b0};
    clr = 1'b1;
    activate = 1'b0;
    attack = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
    end
    activate = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk_idle("held_over_reset");
    end
    foreach (tab[i]) begin
      build_tab(tab[i]);
      start_req(tab[i].a);
      observe(F + 3, 0, 16'h0);
    end
    build_exp(16'h0001);
    start_req(16'h0001);
    observe(500, 2, 16'h0);
    build_exp(16'h1234);
    start_req(16'h1234);
    observe(F + 1, 3, 16'h8000);
    build_exp(16'h8000);
    @(negedge clk);
    observe(F + 3, 0, 16'h0);
    build_exp(16'hC3E1);
    start_req(16'hC3E1);
    observe(150, 0, 16'h0);
    clr = 1'b1;
    @(negedge clk);
    chk_idle("clr_mid");
    clr = 1'b0;
    repeat (F + 20) begin
      @(negedge clk);
      chk_idle("after_clr");
    end
    build_exp(16'h5AC3);
    start_req(16'h5AC3);
    observe(F + 3, 0, 16'h0);
    for (int r = 0; r < 8; r++) begin
      logic [15:0] a;
      a = 16'($urandom);
      activate = 1'b0;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      build_exp(a);
      start_req(a);
      observe(F + 2, 1, 16'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
